// File: rtl/ballot_issuer.sv
// Ballot/IN voting transmitter: keypad strobe -> timed Ballot pulse, gap, code window, recovery.
// Optional build macro BALLOT_ISSUER_ONEHOT_EN restricts legal keypad codes to one-hot values.
module ballot_issuer #(
    parameter int BALLOT_CYC  = 3,
    parameter int GAP_CYC     = 2,
    parameter int CODE_CYC    = 2,
    parameter int RECOVER_CYC = 10
) (
    input  logic        clk,
    input  logic        Clear,
    input  logic        Power,
    input  logic        Close,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        Ballot,
    output logic [3:0]  IN,
    output logic        busy,
    output logic        closed,
    output logic        reject,
    output logic [11:0] ballot_count
);
    localparam int MAX_AB = (BALLOT_CYC > GAP_CYC) ? BALLOT_CYC : GAP_CYC;
    localparam int MAX_CR = (CODE_CYC > RECOVER_CYC) ? CODE_CYC : RECOVER_CYC;
    localparam int MAXC   = (MAX_AB > MAX_CR) ? MAX_AB : MAX_CR;
    localparam int CW     = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

    typedef enum logic [2:0] {IDLE, ARM, GAP, DRIVE, RECOVER} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  code_q, code_d;
    logic        closed_q, closed_d;
    logic [11:0] count_q, count_d;
    logic        ballot_q, ballot_d;
    logic [3:0]  in_q, in_d;
    logic        busy_q, busy_d;
    logic        reject_q, reject_d;
    logic        legal;
    logic        accept;

`ifdef BALLOT_ISSUER_ONEHOT_EN
    assign legal = (key_code != 4'd0) && ((key_code & (key_code - 4'd1)) == 4'd0);
`else
    assign legal = (key_code != 4'd0);
`endif

    // Close arriving with a key must refuse it, hence the check on the raw input too.
    assign accept = (state_q == IDLE) && Power && !closed_q && !Close && key_valid && legal;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        count_d  = count_q;
        closed_d = closed_q | Close;
        reject_d = key_valid && !accept;
        if (!Power) begin
            state_d = IDLE;
            cnt_d   = '0;
            code_d  = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = ARM;
                        cnt_d   = CW'(BALLOT_CYC - 1);
                        code_d  = key_code;
                    end
                end
                ARM: begin
                    if (cnt_q == '0) begin
                        state_d = GAP;
                        cnt_d   = CW'(GAP_CYC - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = DRIVE;
                        cnt_d   = CW'(CODE_CYC - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d = RECOVER;
                        cnt_d   = CW'(RECOVER_CYC - 1);
                        if (count_q != 12'hFFF) count_d = count_q + 12'd1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        code_d  = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // Pin drivers decode the next state so they line up with the state register.
        ballot_d = (state_d == ARM);
        in_d     = (state_d == DRIVE) ? code_d : 4'd0;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            code_q   <= 4'd0;
            closed_q <= 1'b0;
            count_q  <= 12'd0;
            ballot_q <= 1'b0;
            in_q     <= 4'd0;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            closed_q <= closed_d;
            count_q  <= count_d;
            ballot_q <= ballot_d;
            in_q     <= in_d;
            busy_q   <= busy_d;
            reject_q <= reject_d;
        end
    end

    assign Ballot       = ballot_q;
    assign IN           = in_q;
    assign busy         = busy_q;
    assign closed       = closed_q;
    assign reject       = reject_q;
    assign ballot_count = count_q;
endmodule

// File: tb/tb_ballot_issuer.sv
// Bench for ballot_issuer: stimulus queues expected votes/rejects, a negedge monitor reconstructs
// each vote from the pins (Ballot length, gap, code window, count, timing) and compares.
`timescale 1ns/1ps
module tb_ballot_issuer;
    logic        clk = 1'b0;
    logic        Clear, Power, Close, key_valid;
    logic [3:0]  key_code;
    logic        Ballot, busy, closed, reject;
    logic [3:0]  IN;
    logic [11:0] ballot_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] code;
        int         blen;
        int         gap;
        int         ilen;
        int         cnt;
        longint     tend;
    } vote_t;

    vote_t  vote_q[$];
    longint rej_q[$];
    int     exp_count = 0;

    int         blen = 0, gapc = 0, ilen = 0, overlap = 0;
    logic [3:0] icode = 4'd0;
    logic       prev_ballot = 1'b0;

    ballot_issuer dut (
        .clk(clk), .Clear(Clear), .Power(Power), .Close(Close),
        .key_valid(key_valid), .key_code(key_code),
        .Ballot(Ballot), .IN(IN), .busy(busy), .closed(closed),
        .reject(reject), .ballot_count(ballot_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mode 0: expect reject, 1: expect a full vote, 2: accepted but aborted (nothing expected)
    task automatic key(input logic [3:0] c, input int mode);
        vote_t  v;
        longint t;
        t = $time;
        key_valid = 1'b1;
        key_code  = c;
        if (mode == 0) begin
            rej_q.push_back(t + 10);
        end else if (mode == 1) begin
            exp_count = (exp_count < 4095) ? exp_count + 1 : 4095;
            v.code = c; v.blen = 3; v.gap = 2; v.ilen = 2; v.cnt = exp_count; v.tend = t + 80;
            vote_q.push_back(v);
        end
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    always @(negedge clk) begin
        vote_t v;
        if (Ballot === 1'b1 && IN !== 4'd0) overlap++;
        if (Ballot === 1'b1) begin
            if (!prev_ballot) blen = 0;
            blen++;
            gapc = 0;
        end else if (IN !== 4'd0 && IN !== 4'bx) begin
            if (ilen == 0) icode = IN;
            ilen++;
        end else begin
            if (ilen > 0) begin
                if (vote_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_vote actual_code=%0d required=none", icode);
                end else begin
                    v = vote_q.pop_front();
                    chk("vote_code", icode, v.code);
                    chk("vote_ballot_len", blen, v.blen);
                    chk("vote_gap_len", gapc, v.gap);
                    chk("vote_code_len", ilen, v.ilen);
                    chk("vote_count", ballot_count, v.cnt);
                    chk("vote_end_time", $time, v.tend);
                end
                ilen = 0;
            end
            gapc++;
        end
        prev_ballot = (Ballot === 1'b1);
        if (reject === 1'b1) begin
            if (rej_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_reject actual_time=%0t required=none", $time);
            end else begin
                chk("reject_time", $time, rej_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Clear = 1'b1; Power = 1'b0; Close = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        wait_n(2);
        Clear = 1'b0;
        chk("rst_ballot", Ballot, 0);
        chk("rst_in", IN, 0);
        chk("rst_busy", busy, 0);
        chk("rst_closed", closed, 0);
        chk("rst_reject", reject, 0);
        chk("rst_count", ballot_count, 0);
        Power = 1'b1;

        // Basic vote with busy window edges
        key(4'b0001, 1);
        chk("basic_ballot_e1", Ballot, 1);
        chk("basic_busy_e1", busy, 1);
        wait_n(16);
        chk("basic_busy_e17", busy, 1);
        wait_n(1);
        chk("basic_busy_e18", busy, 0);
        chk("basic_count", ballot_count, 1);

        // Busy lockout: second key 4 cycles after the first
        key(4'b0001, 1);
        wait_n(3);
        key(4'b0010, 0);
        wait_n(13);
        chk("lockout_count", ballot_count, exp_count);

        // Code legality
        key(4'b0000, 0);
`ifdef BALLOT_ISSUER_ONEHOT_EN
        key(4'b0101, 0);
`else
        key(4'b0101, 1);
        wait_n(17);
`endif
        chk("legal_count", ballot_count, exp_count);
        key(4'b1000, 1);
        wait_n(17);

        // Close during DRIVE
        key(4'b0100, 1);
        wait_n(5);
        Close = 1'b1;
        wait_n(1);
        Close = 1'b0;
        chk("close_flag", closed, 1);
        wait_n(11);
        chk("close_count", ballot_count, exp_count);
        key(4'b1000, 0);
        key(4'b0001, 0);
        chk("close_busy", busy, 0);
        Clear = 1'b1;
        wait_n(1);
        Clear = 1'b0;
        exp_count = 0;
        chk("clear_closed", closed, 0);
        chk("clear_count", ballot_count, 0);

        // Close together with a key
        Close = 1'b1;
        key(4'b0010, 0);
        Close = 1'b0;
        chk("close_with_key_flag", closed, 1);
        chk("close_with_key_busy", busy, 0);
        Clear = 1'b1;
        wait_n(1);
        Clear = 1'b0;

        // Power glitch during ARM
        key(4'b0001, 2);
        Power = 1'b0;
        wait_n(1);
        chk("pwr_ballot", Ballot, 0);
        chk("pwr_busy", busy, 0);
        wait_n(1);
        Power = 1'b1;
        chk("pwr_count", ballot_count, exp_count);
        key(4'b0010, 1);
        wait_n(17);

        // Clear during GAP
        key(4'b0100, 2);
        wait_n(3);
        Clear = 1'b1;
        wait_n(1);
        Clear = 1'b0;
        exp_count = 0;
        chk("midclr_ballot", Ballot, 0);
        chk("midclr_in", IN, 0);
        chk("midclr_busy", busy, 0);
        chk("midclr_count", ballot_count, 0);
        wait_n(20);

        // Saturation
        for (int i = 0; i < 4100; i++) begin
            key(4'b0001, 1);
            wait_n(17);
        end
        chk("sat_count", ballot_count, 4095);

        wait_n(5);
        chk("no_overlap", overlap, 0);
        chk("votes_drained", vote_q.size(), 0);
        chk("rejects_drained", rej_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
